hex_scroller: RTL



---
 rtl/hex_scroller_pkg.sv | 24 ++
 rtl/hex_scroller_key_debounce.sv | 50 +++++
 rtl/hex_scroller.sv | 103 ++++++++++
 3 files changed

// File: rtl/hex_scroller_pkg.sv
// Shared constants for the DE10-Lite hex scroller.
// Holds the active-low seven-segment glyph table (g..a), the
// decimal-point and blank codes, the KEY bit assignments, and the
// glyph decoder function that builds one HEX byte.
package hex_scroller_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic       DP_OFF    = 1'b1;

  localparam int KEY_PAUSE = 0;
  localparam int KEY_DIR   = 1;

  // Indexed by glyph code. Entry 15 is the blank glyph.
  localparam logic [15:0][6:0] GLYPH_TABLE = {
    SEG_BLANK, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78,     7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  // One HEX digit byte: {dp, g..a}, all active-low.
  function automatic logic [7:0] glyph(input logic [3:0] code);
    return {DP_OFF, GLYPH_TABLE[code]};
  endfunction

endpackage

// File: rtl/hex_scroller_key_debounce.sv
// Key conditioning for one raw active-low push-button.
// Ports:
//   clk      system clock
//   reset    synchronous active-high reset
//   key_raw  asynchronous button input, pressed = 0
//   press    one-cycle pulse when the debounced level goes 1 -> 0
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic key_raw,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          state;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      state <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= key_raw;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 != state) begin
        // The disagreeing sample that completes the run flips the state.
        if (cnt == CNT_LAST) begin
          state <= sync2;
          cnt   <= '0;
          press <= state;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/hex_scroller.sv
// Scrolls a window of six hex glyphs across HEX5..HEX0 of the DE10-Lite.
// Ports:
//   CLK     system clock (50 MHz)
//   RESET   synchronous active-high reset
//   KEY     raw buttons, active-low; KEY[0] toggles pause, KEY[1] direction
//   DIGITS  message glyph codes, character i at DIGITS[4i+3:4i]
//   HEX     registered active-low segment bus, HEXk = HEX[8k+7:8k]
//   LED     registered status: [9] step toggle, [8] dir, [7] paused,
//           [3:0] window position
module hex_scroller
  import hex_scroller_pkg::*;
#(
  parameter int MSG_LEN         = 8,
  parameter int STEP_CYCLES     = 25000000,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [1:0]           KEY,
  input  logic [4*MSG_LEN-1:0] DIGITS,
  output logic [47:0]          HEX,
  output logic [9:0]           LED
);

  localparam int CW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(STEP_CYCLES - 1);
  localparam logic [3:0]    POS_LAST = 4'(MSG_LEN - 1);

  logic          press_pause;
  logic          press_dir;
  logic [3:0]    pos;
  logic          paused;
  logic          dir;
  logic          step_tgl;
  logic [CW-1:0] cnt;

  logic          run;
  logic          step;
  logic          dir_new;
  logic [3:0]    pos_next;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_pause (
    .clk     (CLK),
    .reset   (RESET),
    .key_raw (KEY[KEY_PAUSE]),
    .press   (press_pause)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_dir (
    .clk     (CLK),
    .reset   (RESET),
    .key_raw (KEY[KEY_DIR]),
    .press   (press_dir)
  );

  // HEX(5-k) shows character (p+k) mod MSG_LEN.
  function automatic logic [47:0] window(input logic [3:0] p,
                                         input logic [4*MSG_LEN-1:0] d);
    logic [47:0] w;
    int          idx;
    w = '1;
    for (int k = 0; k < 6; k++) begin
      idx = int'(p) + k;
      if (idx >= MSG_LEN) idx = idx - MSG_LEN;
      w[8*(5-k) +: 8] = glyph(d[4*idx +: 4]);
    end
    return w;
  endfunction

  always_comb begin
    // A pause press freezes the counter in the cycle it arrives, which is
    // what suppresses a step that would otherwise land on that edge.
    run     = !paused && !press_pause;
    step    = run && (cnt == CNT_LAST);
    // A direction press in a step cycle steers that same step.
    dir_new = dir ^ press_dir;
    if (!dir_new) pos_next = (pos == POS_LAST) ? 4'd0 : pos + 4'd1;
    else          pos_next = (pos == 4'd0) ? POS_LAST : pos - 4'd1;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      pos      <= '0;
      paused   <= 1'b0;
      dir      <= 1'b0;
      step_tgl <= 1'b0;
      cnt      <= '0;
      HEX      <= '1;
      LED      <= '0;
    end else begin
      dir <= dir_new;
      if (press_pause) paused <= !paused;
      if (run) cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
      if (step) begin
        pos      <= pos_next;
        step_tgl <= !step_tgl;
      end
      HEX <= window(pos, DIGITS);
      LED <= {step_tgl, dir, paused, 3'b000, pos};
    end
  end

endmodule
